// File: rtl/ac97_stream_bridge_pkg.sv
//------------------------------------------------------------------------------
// Module  : ac97_stream_bridge_pkg
// Purpose : Shared AC97 slot constants and sample left-justify helper, used by
//           the stream bridge and the frame serialiser.
// Ports   : none (package)
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package ac97_stream_bridge_pkg;

  // Width of one AC97 PCM slot.
  localparam int AC97_SLOT_W = 20;

  // Left-justify a zero-extended sample of 'width' bits into a full slot.
  function automatic logic [AC97_SLOT_W-1:0] ac97_left_justify(
    input logic [AC97_SLOT_W-1:0] sample,
    input int                     width
  );
    return sample << (AC97_SLOT_W - width);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ac97_stream_bridge_if.sv
//------------------------------------------------------------------------------
// Module  : ac97_stream_bridge_if
// Purpose : User-side sample stream of the AC97 bridge: outgoing valid/ready
//           sample pairs and the per-frame captured input pair.
// Ports   : master - user logic (drives out_*, receives out_ready and in_*)
//           slave  - bridge     (receives out_*, drives out_ready and in_*)
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface ac97_stream_bridge_if #(
  parameter int SAMPLE_W = 8
);
  logic                out_valid;
  logic                out_ready;
  logic [SAMPLE_W-1:0] out_left;
  logic [SAMPLE_W-1:0] out_right;
  logic                in_valid;
  logic [SAMPLE_W-1:0] in_left;
  logic [SAMPLE_W-1:0] in_right;

  modport master (
    output out_valid, out_left, out_right,
    input  out_ready, in_valid, in_left, in_right
  );

  modport slave (
    input  out_valid, out_left, out_right,
    output out_ready, in_valid, in_left, in_right
  );
endinterface

`default_nettype wire

// File: rtl/ac97_stream_bridge_sync_fifo.sv
//------------------------------------------------------------------------------
// Module  : sync_fifo
// Purpose : Single-clock FIFO with occupancy count. Push is ignored when full,
//           pop is ignored when empty; data_o shows the head entry.
// Ports   : clk_i, rst_i (sync, active-high), push_i/data_i, pop_i/data_o,
//           full_o, empty_o, level_o (0..DEPTH)
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             w_push, w_pop;

  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

  // DEPTH is a power of two, so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (w_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (w_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({w_push, w_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: emptied pointers make old contents unreachable.
  always_ff @(posedge clk_i) begin
    if (w_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

`default_nettype wire

// File: rtl/ac97_stream_bridge.sv
//------------------------------------------------------------------------------
// Module  : ac97_stream_bridge
// Purpose : Bridge between user audio logic and the AC97 frame serialiser.
//           Outgoing sample pairs are buffered in a FIFO and one pair is popped
//           per AC97 frame; one incoming pair is captured per frame.
// Ports   : clock_27mhz, reset (sync, active-high), ac97_ready (async),
//           bus (user stream, slave side), left/right_out_data (to AC97),
//           left/right_in_data (from AC97), frame_tick, fifo_level,
//           underrun_count (saturating)
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module ac97_stream_bridge
  import ac97_stream_bridge_pkg::*;
#(
  parameter int SAMPLE_W      = 8,
  parameter int FIFO_DEPTH    = 16,
  parameter int STEREO        = 1,
  parameter int UNDERRUN_HOLD = 1
) (
  input  logic                        clock_27mhz,
  input  logic                        reset,
  input  logic                        ac97_ready,
  ac97_stream_bridge_if.slave         bus,
  output logic [AC97_SLOT_W-1:0]      left_out_data,
  output logic [AC97_SLOT_W-1:0]      right_out_data,
  input  logic [AC97_SLOT_W-1:0]      left_in_data,
  input  logic [AC97_SLOT_W-1:0]      right_in_data,
  output logic                        frame_tick,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [15:0]                 underrun_count
);
  logic [2:0]               sync_q;
  logic [2*SAMPLE_W-1:0]    w_head;
  logic                     w_full, w_empty, w_pop;
  logic [AC97_SLOT_W-1:0]   w_slot_left, w_slot_right;
  logic [SAMPLE_W-1:0]      w_cap_left, w_cap_right;
  logic [AC97_SLOT_W-1:0]   left_q, left_d, right_q, right_d;
  logic [SAMPLE_W-1:0]      in_left_q, in_left_d, in_right_q, in_right_d;
  logic                     in_valid_q;
  logic [15:0]              urc_q, urc_d;
  logic                     w_unused;

  // Synchroniser resets to all-ones so a ready line already high out of reset
  // does not look like a rising edge.
  always_ff @(posedge clock_27mhz) begin
    if (reset) sync_q <= 3'b111;
    else       sync_q <= {sync_q[1:0], ac97_ready};
  end
  assign frame_tick = sync_q[1] & ~sync_q[2];

  assign w_pop = frame_tick & ~w_empty;

  sync_fifo #(
    .WIDTH (2*SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clock_27mhz),
    .rst_i   (reset),
    .push_i  (bus.out_valid),
    .data_i  ({bus.out_left, bus.out_right}),
    .pop_i   (w_pop),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .level_o (fifo_level)
  );
  assign bus.out_ready = ~w_full;

  assign w_slot_left = ac97_left_justify(AC97_SLOT_W'(w_head[2*SAMPLE_W-1 -: SAMPLE_W]), SAMPLE_W);
  assign w_cap_left  = left_in_data[AC97_SLOT_W-1 -: SAMPLE_W];

  generate
    if (STEREO != 0) begin : g_stereo
      assign w_slot_right = ac97_left_justify(AC97_SLOT_W'(w_head[SAMPLE_W-1:0]), SAMPLE_W);
      assign w_cap_right  = right_in_data[AC97_SLOT_W-1 -: SAMPLE_W];
    end else begin : g_mono
      assign w_slot_right = w_slot_left;
      assign w_cap_right  = w_cap_left;
    end
  endgenerate

  // Slot bits below the sample, and the right channel in mono, are don't-care.
  assign w_unused = ^{left_in_data, right_in_data, bus.out_right};

  always_comb begin
    left_d     = left_q;
    right_d    = right_q;
    in_left_d  = in_left_q;
    in_right_d = in_right_q;
    urc_d      = urc_q;
    if (frame_tick) begin
      in_left_d  = w_cap_left;
      in_right_d = w_cap_right;
      if (!w_empty) begin
        left_d  = w_slot_left;
        right_d = w_slot_right;
      end else begin
        if (UNDERRUN_HOLD == 0) begin
          left_d  = '0;
          right_d = '0;
        end
        if (urc_q != 16'hFFFF) urc_d = urc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock_27mhz) begin
    if (reset) begin
      left_q     <= '0;
      right_q    <= '0;
      in_left_q  <= '0;
      in_right_q <= '0;
      in_valid_q <= 1'b0;
      urc_q      <= '0;
    end else begin
      left_q     <= left_d;
      right_q    <= right_d;
      in_left_q  <= in_left_d;
      in_right_q <= in_right_d;
      in_valid_q <= frame_tick;
      urc_q      <= urc_d;
    end
  end

  assign left_out_data  = left_q;
  assign right_out_data = right_q;
  assign bus.in_valid   = in_valid_q;
  assign bus.in_left    = in_left_q;
  assign bus.in_right   = in_right_q;
  assign underrun_count = urc_q;

endmodule

`default_nettype wire
